// File: rtl/gcd_engine.sv
// Euclidean GCD engine: repeated remainder steps, each remainder computed by a
// restoring shift-subtract divider that retires one quotient bit per clock.
module gcd_engine #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ITER_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [WIDTH-1:0]  result_o,
    output logic [ITER_W-1:0] iter_cnt_o
);

    localparam int unsigned       CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0]   CntLoad = CntW'(WIDTH);
    localparam logic [ITER_W-1:0] IterMax = '1;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StMod,
        StUpdate,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;

    logic [WIDTH:0] trial;
    logic [WIDTH:0] y_ext;
    logic           a_ge_b;

    // Partial remainder shifted left with the next dividend bit brought in.
    assign trial  = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign y_ext  = {1'b0, y_q};
    assign a_ge_b = (a_i >= b_i);

    // The remainder MSB is always 0 after a restoring step (rem < y).
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start_i) state_d = StCheck;
            StCheck:  state_d = (y_q == '0) ? StDone : StMod;
            StMod:    if (bit_cnt_q == CntW'(1)) state_d = StUpdate;
            StUpdate: state_d = StCheck;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (abort_i) state_d = StIdle;
    end

    // Moore-decoded handshake outputs
    always_comb begin
        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
    end

    // Datapath next-state; an abort freezes all registers, so results are kept
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        rem_d      = rem_q;
        q_d        = q_q;
        bit_cnt_d  = bit_cnt_q;
        iter_d     = iter_q;
        result_d   = result_q;
        iter_cnt_d = iter_cnt_q;
        if (!abort_i) begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        x_d    = a_ge_b ? a_i : b_i;
                        y_d    = a_ge_b ? b_i : a_i;
                        iter_d = '0;
                    end
                end
                StCheck: begin
                    if (y_q == '0) begin
                        result_d   = x_q;
                        iter_cnt_d = iter_q;
                    end else begin
                        q_d       = x_q;
                        rem_d     = '0;
                        bit_cnt_d = CntLoad;
                    end
                end
                StMod: begin
                    q_d       = q_q << 1;
                    rem_d     = (trial >= y_ext) ? (trial - y_ext) : trial;
                    bit_cnt_d = bit_cnt_q - CntW'(1);
                end
                StUpdate: begin
                    x_d = y_q;
                    y_d = rem_q[WIDTH-1:0];
                    if (iter_q != IterMax) iter_d = iter_q + ITER_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q        <= '0;
            y_q        <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            bit_cnt_q  <= '0;
            iter_q     <= '0;
            result_q   <= '0;
            iter_cnt_q <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            rem_q      <= rem_d;
            q_q        <= q_d;
            bit_cnt_q  <= bit_cnt_d;
            iter_q     <= iter_d;
            result_q   <= result_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    assign result_o   = result_q;
    assign iter_cnt_o = iter_cnt_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: a 16-bit and an 8-bit (2-bit iteration counter) instance,
// an arithmetic reference model checked every cycle, plus directed runs.
module tb_gcd_engine;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    logic        s16 = 1'b0, ab16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [15:0] res16;
    logic [7:0]  it16;

    logic       s8 = 1'b0, ab8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8;
    logic [7:0] res8;
    logic [1:0] it8;

    int          n_chk = 0;
    int          n_pass = 0;
    int unsigned edge_cnt = 0;
    bit          cmp_en = 1'b0;

    gcd_engine #(.WIDTH(16), .ITER_W(8)) dut16 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(s16), .a_i(a16), .b_i(b16),
        .abort_i(ab16), .busy_o(busy16), .done_o(done16), .result_o(res16),
        .iter_cnt_o(it16)
    );

    gcd_engine #(.WIDTH(8), .ITER_W(2)) dut8 (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(s8), .a_i(a8), .b_i(b8),
        .abort_i(ab8), .busy_o(busy8), .done_o(done8), .result_o(res8),
        .iter_cnt_o(it8)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned x, y, r;
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        while (y != 0) begin
            r = x % y;
            x = y;
            y = r;
        end
        return x;
    endfunction

    function automatic int unsigned ref_steps(input int unsigned a, input int unsigned b);
        int unsigned x, y, r, k;
        x = (a > b) ? a : b;
        y = (a > b) ? b : a;
        k = 0;
        while (y != 0) begin
            r = x % y;
            x = y;
            y = r;
            k++;
        end
        return k;
    endfunction

    function automatic int unsigned sat(input int unsigned v, input int unsigned m);
        return (v > m) ? m : v;
    endfunction

    always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

    // Reference model: a run accepted on edge e enters DONE on edge e+1+k*(W+2)
    logic        m16_act, m16_dn;
    logic [15:0] m16_res, m16_pres;
    logic [7:0]  m16_it, m16_pit;
    int unsigned m16_edge;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m16_act <= 1'b0; m16_dn <= 1'b0; m16_res <= '0; m16_it <= '0;
            m16_pres <= '0; m16_pit <= '0; m16_edge <= 0;
        end else if (ab16 || m16_dn) begin
            m16_act <= 1'b0;
            m16_dn  <= 1'b0;
        end else if (m16_act) begin
            if (edge_cnt == m16_edge) begin
                m16_dn  <= 1'b1;
                m16_res <= m16_pres;
                m16_it  <= m16_pit;
            end
        end else if (s16) begin
            m16_act  <= 1'b1;
            m16_edge <= edge_cnt + 1 + ref_steps(a16, b16) * 18;
            m16_pres <= 16'(ref_gcd(a16, b16));
            m16_pit  <= 8'(sat(ref_steps(a16, b16), 255));
        end
    end

    logic       m8_act, m8_dn;
    logic [7:0] m8_res, m8_pres;
    logic [1:0] m8_it, m8_pit;
    int unsigned m8_edge;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m8_act <= 1'b0; m8_dn <= 1'b0; m8_res <= '0; m8_it <= '0;
            m8_pres <= '0; m8_pit <= '0; m8_edge <= 0;
        end else if (ab8 || m8_dn) begin
            m8_act <= 1'b0;
            m8_dn  <= 1'b0;
        end else if (m8_act) begin
            if (edge_cnt == m8_edge) begin
                m8_dn  <= 1'b1;
                m8_res <= m8_pres;
                m8_it  <= m8_pit;
            end
        end else if (s8) begin
            m8_act  <= 1'b1;
            m8_edge <= edge_cnt + 1 + ref_steps(a8, b8) * 10;
            m8_pres <= 8'(ref_gcd(a8, b8));
            m8_pit  <= 2'(sat(ref_steps(a8, b8), 3));
        end
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("cyc16 busy/done/result/iter", {busy16, done16, res16, it16},
                {m16_act, m16_dn, m16_res, m16_it});
            chk("cyc8 busy/done/result/iter", {busy8, done8, res8, it8},
                {m8_act, m8_dn, m8_res, m8_it});
        end
    end

    task automatic start16(input logic [15:0] a, input logic [15:0] b);
        @(posedge clk_i); #1;
        s16 = 1'b1; a16 = a; b16 = b;
        @(posedge clk_i); #1;
        s16 = 1'b0;
    endtask

    task automatic wait_done16(input int n0, output int lat);
        int n = n0 - 1;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            n++;
            if (done16) begin
                lat = n;
                return;
            end
        end
        chk("timeout16", 0, 1);
    endtask

    task automatic run16(input string nm, input logic [15:0] a, input logic [15:0] b,
                         input int er, input int ei, input int el);
        int lat;
        start16(a, b);
        wait_done16(1, lat);
        chk({nm, "_lat"}, lat, el);
        chk({nm, "_res"}, res16, er);
        chk({nm, "_iter"}, it16, ei);
    endtask

    task automatic run8(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input int er, input int ei, input int el);
        int n = 0;
        int lat = -1;
        @(posedge clk_i); #1;
        s8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk_i); #1;
        s8 = 1'b0;
        for (int i = 0; i < 2000 && lat < 0; i++) begin
            @(negedge clk_i);
            n++;
            if (done8) lat = n;
        end
        if (lat < 0) chk({nm, "_timeout"}, 0, 1);
        chk({nm, "_lat"}, lat, el);
        chk({nm, "_res"}, res8, er);
        chk({nm, "_iter"}, it8, ei);
    endtask

    initial begin
        int lat;
        #1 rst_ni = 1'b0;
        #1;
        chk("rst16", {busy16, done16, res16, it16}, 0);
        chk("rst8", {busy8, done8, res8, it8}, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        cmp_en = 1'b1;

        // Pin the reference model itself
        chk("pin_gcd_48_18", ref_gcd(48, 18), 6);
        chk("pin_steps_48_18", ref_steps(48, 18), 3);
        chk("pin_steps_fib", ref_steps(233, 144), 11);

        run16("g48_18", 16'd48, 16'd18, 6, 3, 56);
        run16("g18_48", 16'd18, 16'd48, 6, 3, 56);
        run16("g0_35", 16'd0, 16'd35, 35, 0, 2);
        run16("g0_0", 16'd0, 16'd0, 0, 0, 2);
        run16("gff_fe", 16'hFFFF, 16'hFFFE, 1, 2, 38);
        run16("gff_ff", 16'hFFFF, 16'hFFFF, 65535, 1, 20);

        // Start pulsed mid-run is ignored
        start16(16'd48, 16'd18);
        repeat (9) @(posedge clk_i);
        #1 s16 = 1'b1; a16 = 16'd7; b16 = 16'd3;
        @(posedge clk_i); #1 s16 = 1'b0;
        wait_done16(11, lat);
        chk("ign_lat", lat, 56);
        chk("ign_res", res16, 6);
        run16("fresh7_3", 16'd7, 16'd3, 1, 2, 38);

        // Abort inside MOD: idle next cycle, prior result kept
        start16(16'd48, 16'd18);
        repeat (4) @(posedge clk_i);
        #1 ab16 = 1'b1;
        @(posedge clk_i); #1 ab16 = 1'b0;
        chk("abort_busy", busy16, 0);
        chk("abort_res", res16, 1);
        repeat (60) @(posedge clk_i);
        chk("abort_res_late", res16, 1);

        // Abort together with start in idle: start ignored
        @(posedge clk_i); #1;
        s16 = 1'b1; ab16 = 1'b1; a16 = 16'd5; b16 = 16'd10;
        @(posedge clk_i); #1;
        s16 = 1'b0; ab16 = 1'b0;
        chk("abort_start_busy", busy16, 0);

        // Asynchronous reset mid-MOD clears outputs immediately
        start16(16'd48, 16'd18);
        repeat (8) @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst16", {busy16, done16, res16, it16}, 0);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        run16("post_rst", 16'd12, 16'd8, 4, 2, 38);

        run8("fib233_144", 8'd233, 8'd144, 1, 3, 112);
        run8("g8_0_255", 8'd0, 8'd255, 255, 0, 2);
        run8("g8_100_75", 8'd100, 8'd75, 25, 2, 22);

        repeat (3) @(posedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
